// File: rtl/a2d_pkg.sv
// ----------------------------------------------------------------------------
// a2d_pkg
// Shared types and helpers for the ADC128S SPI master.
//   a2d_state_t : conversion sequencer states (IDLE, TX1, GAP, TX2)
//   A2D_RES_W   : width of a conversion result
//   a2d_cmd()   : builds the 16-bit command word for a channel
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package a2d_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TX1  = 2'd1,
    GAP  = 2'd2,
    TX2  = 2'd3
  } a2d_state_t;

  localparam int A2D_RES_W = 12;

  // Channel address sits in bits [13:11]; all other bits are zero.
  function automatic logic [15:0] a2d_cmd(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

endpackage

`default_nettype wire

// File: rtl/a2d_spi_master_spi_mstr16.sv
// ----------------------------------------------------------------------------
// spi_mstr16
// Single 16-bit SPI transaction engine (mode 3 style: SCLK idles high,
// MOSI changes on falling SCLK, MISO sampled on rising SCLK).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   wrt          : start a transaction with cmd (ignored while busy)
//   cmd[15:0]    : word shifted out MSB first
//   done         : one-clk pulse after SS_n rises
//   rd_data[15:0]: word shifted in from MISO, valid with done
//   SS_n, SCLK, MOSI, MISO : SPI pins
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module spi_mstr16 #(
  parameter int SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int HALF      = SCLK_DIV / 2;
  localparam int XFER_CLKS = HALF + 16 * SCLK_DIV;
  localparam int CNT_W     = $clog2(XFER_CLKS);
  // Bit of the transaction counter that selects the low half of each SCLK
  // period; the front porch makes the counter phase line up with it.
  localparam int HB        = $clog2(SCLK_DIV) - 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(XFER_CLKS - 1);
  localparam logic [CNT_W-1:0] FIRST_FALL = CNT_W'(HALF);

  logic             ss_n_q;
  logic             sclk_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      shft_q;
  logic             miso_smpl_q;
  logic             done_q;

  logic [CNT_W-1:0] cnt_d;
  logic             sclk_d;

  assign cnt_d  = cnt_q + 1'b1;
  assign sclk_d = ~cnt_d[HB];

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_n_q      <= 1'b1;
      sclk_q      <= 1'b1;
      cnt_q       <= '0;
      shft_q      <= '0;
      miso_smpl_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (ss_n_q) begin
        if (wrt) begin
          ss_n_q <= 1'b0;
          sclk_q <= 1'b1;
          cnt_q  <= '0;
          shft_q <= cmd;
        end
      end else if (cnt_q == CNT_LAST) begin
        // End of period 16: last shift replaces a 17th falling edge.
        ss_n_q <= 1'b1;
        sclk_q <= 1'b1;
        cnt_q  <= '0;
        shft_q <= {shft_q[14:0], miso_smpl_q};
        done_q <= 1'b1;
      end else begin
        cnt_q  <= cnt_d;
        sclk_q <= sclk_d;
        // The first fall has no sample behind it yet, so it does not shift.
        if (sclk_q && !sclk_d && (cnt_d != FIRST_FALL)) begin
          shft_q <= {shft_q[14:0], miso_smpl_q};
        end
        if (!sclk_q && sclk_d) begin
          miso_smpl_q <= MISO;
        end
      end
    end
  end

  assign SS_n    = ss_n_q;
  assign SCLK    = sclk_q;
  assign MOSI    = shft_q[15] & ~ss_n_q;
  assign done    = done_q;
  assign rd_data = shft_q;

endmodule

`default_nettype wire

// File: rtl/a2d_spi_master.sv
// ----------------------------------------------------------------------------
// a2d_spi_master
// Drives the ADC128S 8-channel, 12-bit A2D. A conversion is two 16-bit SPI
// transactions separated by a short SS_n-high gap: the first carries the
// channel command, the second returns that channel's result.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   strt_cnv   : 1-clk pulse, start a conversion on chnnl (IDLE only)
//   chnnl[2:0] : channel, sampled with strt_cnv
//   cnv_cmplt  : result valid, held until the next accepted strt_cnv
//   res[11:0]  : last conversion result
//   SS_n, SCLK, MOSI, MISO : A2D SPI pins
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module a2d_spi_master
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV = 32,
  parameter int GAP_CLKS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 strt_cnv,
  input  logic [2:0]           chnnl,
  output logic                 cnv_cmplt,
  output logic [A2D_RES_W-1:0] res,
  output logic                 SS_n,
  output logic                 SCLK,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam int GAP_W = $clog2(GAP_CLKS);
  // The engine drops SS_n one clk after wrt and GAP is entered one clk after
  // SS_n rises, so the restart is requested two counts early.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 2);

  a2d_state_t           state_q;
  logic [2:0]           chnl_q;
  logic [GAP_W-1:0]     gap_cnt_q;
  logic                 cnv_cmplt_q;
  logic [A2D_RES_W-1:0] res_q;

  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;
  logic        unused_rd_hi;

  // Start TX1 in the same clk strt_cnv is accepted; in IDLE the channel
  // register has not been loaded yet, so use the live input.
  assign wrt = ((state_q == IDLE) && strt_cnv) ||
               ((state_q == GAP) && (gap_cnt_q == GAP_LAST));
  assign cmd = (state_q == IDLE) ? a2d_cmd(chnnl) : a2d_cmd(chnl_q);

  // Upper nibble of the returned word carries no result data.
  assign unused_rd_hi = ^rd_data[15:A2D_RES_W];

  spi_mstr16 #(
    .SCLK_DIV (SCLK_DIV)
  ) u_spi (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt),
    .cmd     (cmd),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      chnl_q      <= 3'd0;
      gap_cnt_q   <= '0;
      cnv_cmplt_q <= 1'b0;
      res_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (strt_cnv) begin
            chnl_q      <= chnnl;
            cnv_cmplt_q <= 1'b0;
            state_q     <= TX1;
          end
        end
        TX1: begin
          // Data returned by the first transaction is stale and dropped.
          if (done) begin
            gap_cnt_q <= '0;
            state_q   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= TX2;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        TX2: begin
          if (done) begin
            res_q       <= rd_data[A2D_RES_W-1:0];
            cnv_cmplt_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cnv_cmplt = cnv_cmplt_q;
  assign res       = res_q;

endmodule

`default_nettype wire
